// File: rtl/psg_wave_fetch_pkg.sv
// Shared types and constants for the PSG wave-fetch bus engine.
package psg_pkg;

  localparam int PSG_NCH = 8;

  typedef enum logic [1:0] {ARB, GRANT, BUS, DONE} psg_fetch_state_t;

  function automatic logic [PSG_NCH-1:0] psg_ch_onehot(input logic [2:0] ch);
    return PSG_NCH'(1) << ch;
  endfunction

endpackage

// File: rtl/psg_wave_fetch_if.sv
// System-bus read channel between the wave-fetch master and its slave.
interface psg_wave_fetch_if #(
  parameter int AW = 24,
  parameter int DW = 16
);
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic          ack_i;
  logic [DW-1:0] dat_i;

  modport master (output cyc_o, stb_o, we_o, adr_o, input ack_i, dat_i);
  modport slave  (input cyc_o, stb_o, we_o, adr_o, output ack_i, dat_i);
endinterface

// File: rtl/psg_wave_fetch_timeout.sv
// Bus-cycle watchdog: counts BUS clocks without ack, flags expiry on the last one.
module psg_bus_timeout #(
  parameter int TO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt_reg;

  // Expiry is combinational so the FSM leaves BUS on the TO_CYCLES-th idle clock.
  assign expired = run && (cnt_reg == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= '0;
    end else if (run && !expired) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/psg_wave_fetch.sv
// PSG wave-table fetch: runs one bus read per arbiter grant and strobes rdy_o per channel.
// Optional bus watchdog enabled by defining PSG_FETCH_TIMEOUT_EN.
module psg_wave_fetch
  import psg_pkg::*;
#(
  parameter int AW        = 24,
  parameter int DW        = 16,
  parameter int TO_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic [PSG_NCH-1:0]     sel,
  input  logic [2:0]             seln,
  input  logic [PSG_NCH-1:0]     req,
  input  logic [PSG_NCH*AW-1:0]  adr_i,
  output logic                   arb_ack_o,
  psg_wave_fetch_if.master       bus,
  output logic [DW-1:0]          dat_o,
  output logic [PSG_NCH-1:0]     rdy_o,
  output logic                   err_o
);
  psg_fetch_state_t state_reg, state_next;
  logic [2:0]       ch_reg;
  logic [AW-1:0]    adr_reg;
  logic [DW-1:0]    dat_reg;
  logic             err_reg;
  logic [AW-1:0]    ch_adr [PSG_NCH];
  logic             start;
  logic             expired;

  for (genvar gi = 0; gi < PSG_NCH; gi++) begin : g_ch_adr
    assign ch_adr[gi] = adr_i[gi*AW +: AW];
  end

  // A held grant whose owner has stopped requesting must not start a cycle.
  assign start = (state_reg == GRANT) && (|sel) && sel[seln] && req[seln];

`ifdef PSG_FETCH_TIMEOUT_EN
  psg_bus_timeout #(.TO_CYCLES(TO_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .run     ((state_reg == BUS) && !bus.ack_i),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB:     if (ce) state_next = GRANT;
      GRANT:   state_next = start ? BUS : ARB;
      BUS: begin
        if (bus.ack_i)    state_next = DONE;
        else if (expired) state_next = ARB;
      end
      DONE:    state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB;
      ch_reg    <= '0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= (state_reg == BUS) && !bus.ack_i && expired;
      if (start) begin
        ch_reg  <= seln;
        adr_reg <= ch_adr[seln];
      end
      if ((state_reg == BUS) && bus.ack_i) dat_reg <= bus.dat_i;
    end
  end

  // cyc/stb follow the BUS state so an async reset abandons the cycle at once.
  assign arb_ack_o = (state_reg == ARB);
  assign bus.cyc_o = (state_reg == BUS);
  assign bus.stb_o = (state_reg == BUS);
  assign bus.we_o  = 1'b0;
  assign bus.adr_o = adr_reg;
  assign dat_o     = dat_reg;
  assign rdy_o     = (state_reg == DONE) ? psg_ch_onehot(ch_reg) : '0;
  assign err_o     = err_reg;
endmodule

// File: tb/tb_psg_wave_fetch.sv
// Self-checking bench for psg_wave_fetch: vector table plus scoreboard on rdy_o.
module tb_psg_wave_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [7:0]  sel;
  logic [2:0]  seln;
  logic [7:0]  req;
  logic [191:0] adr_i;
  logic        arb_ack_o;
  logic [15:0] dat_o;
  logic [7:0]  rdy_o;
  logic        err_o;

  psg_wave_fetch_if #(.AW(24), .DW(16)) bus_if ();

  psg_wave_fetch #(.AW(24), .DW(16), .TO_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .sel       (sel),
    .seln      (seln),
    .req       (req),
    .adr_i     (adr_i),
    .arb_ack_o (arb_ack_o),
    .bus       (bus_if),
    .dat_o     (dat_o),
    .rdy_o     (rdy_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rdy;
    logic [15:0] dat;
  } exp_t;

  typedef struct {
    int          ch;
    logic [23:0] adr;
    logic [15:0] dat;
    int          wt;
  } vec_t;

  exp_t q[$];
  exp_t e;
  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] prev_rdy = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rdy_o strobe must match the oldest outstanding transfer.
  always @(negedge clk) begin
    if (rst_n && rdy_o != 0) begin
      if (q.size() == 0) begin
        chk("rdy_unexpected", {24'h0, rdy_o}, 32'h0);
      end else begin
        e = q.pop_front();
        $display("xfer: rdy_o=%h dat_o=%h (want %h/%h)", rdy_o, dat_o, e.rdy, e.dat);
        chk("rdy_o", {24'h0, rdy_o}, {24'h0, e.rdy});
        chk("dat_o", {16'h0, dat_o}, {16'h0, e.dat});
        chk("rdy_onehot", {31'h0, $onehot(rdy_o)}, 32'h1);
      end
      if (prev_rdy != 0) chk("rdy_one_clk", {24'h0, prev_rdy}, 32'h0);
    end
    prev_rdy = rst_n ? rdy_o : 8'h0;
  end

  task automatic wait_arb();
    int n = 0;
    while (!arb_ack_o && n < 20) begin
      step();
      n++;
    end
    chk("arb_wait", {31'h0, arb_ack_o}, 32'h1);
  endtask

  // Grant a channel at a ce point and step into the first BUS clock.
  task automatic start_xfer(input int ch, input logic [23:0] adr, input logic [15:0] dat,
                            input bit push);
    exp_t x;
    wait_arb();
    req  = 8'(1) << ch;
    sel  = 8'(1) << ch;
    seln = 3'(ch);
    adr_i[ch*24 +: 24] = adr;
    ce   = 1'b1;
    if (push) begin
      x.rdy = 8'(1) << ch;
      x.dat = dat;
      q.push_back(x);
    end
    step();
    ce = 1'b0;
    chk("grant_ack_low", {31'h0, arb_ack_o}, 32'h0);
    step();
    chk("bus_cyc", {31'h0, bus_if.cyc_o}, 32'h1);
    chk("bus_stb", {31'h0, bus_if.stb_o}, 32'h1);
    chk("bus_we", {31'h0, bus_if.we_o}, 32'h0);
    chk("bus_adr", {8'h0, bus_if.adr_o}, {8'h0, adr});
    chk("bus_ack_low", {31'h0, arb_ack_o}, 32'h0);
  endtask

  task automatic finish_xfer(input int ch, input logic [23:0] adr, input logic [15:0] dat,
                             input int wt);
    for (int i = 0; i < wt; i++) begin
      // Grant and address inputs moving mid-cycle must not disturb the latched channel.
      seln = 3'(ch + 1);
      sel  = 8'(1) << ((ch + 1) % 8);
      adr_i[ch*24 +: 24] = ~adr;
      step();
      chk("wait_cyc", {31'h0, bus_if.cyc_o}, 32'h1);
      chk("wait_adr", {8'h0, bus_if.adr_o}, {8'h0, adr});
      chk("wait_err", {31'h0, err_o}, 32'h0);
    end
    bus_if.ack_i = 1'b1;
    bus_if.dat_i = dat;
    step();
    bus_if.ack_i = 1'b0;
    bus_if.dat_i = 16'($urandom);
    chk("done_cyc", {31'h0, bus_if.cyc_o}, 32'h0);
    chk("done_ack_low", {31'h0, arb_ack_o}, 32'h0);
    step();
    req = 8'h0;
    chk("post_rdy", {24'h0, rdy_o}, 32'h0);
    chk("post_dat_hold", {16'h0, dat_o}, {16'h0, dat});
    chk("post_arb", {31'h0, arb_ack_o}, 32'h1);
  endtask

  initial begin
    vecs[0] = '{ch: 2, adr: 24'h001234, dat: 16'hBEEF, wt: 2};
    vecs[1] = '{ch: 0, adr: 24'h000010, dat: 16'h1111, wt: 0};
    vecs[2] = '{ch: 7, adr: 24'hFFFFFE, dat: 16'h8001, wt: 1};
    vecs[3] = '{ch: 5, adr: 24'h55AA55, dat: 16'hA5A5, wt: 5};
    vecs[4] = '{ch: 4, adr: 24'h800000, dat: 16'h0000, wt: 3};

    rst_n = 1'b0;
    ce = 1'b0; sel = '0; seln = '0; req = '0; adr_i = '0;
    bus_if.ack_i = 1'b0;
    bus_if.dat_i = '0;
    #2;
    chk("rst_arb_ack", {31'h0, arb_ack_o}, 32'h1);
    chk("rst_cyc", {31'h0, bus_if.cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, bus_if.stb_o}, 32'h0);
    chk("rst_we", {31'h0, bus_if.we_o}, 32'h0);
    chk("rst_adr", {8'h0, bus_if.adr_o}, 32'h0);
    chk("rst_dat", {16'h0, dat_o}, 32'h0);
    chk("rst_rdy", {24'h0, rdy_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    #10 rst_n = 1'b1;
    step();

    // Idle: ce pulses with nobody requesting.
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) chk("idle_arb_ack", {31'h0, arb_ack_o}, 32'h1);
      ce = (i % 4 == 0);
      step();
      chk("idle_cyc", {31'h0, bus_if.cyc_o}, 32'h0);
      chk("idle_rdy", {24'h0, rdy_o}, 32'h0);
    end
    ce = 1'b0;

    for (int v = 0; v < 5; v++) begin
      $display("vec %0d: ch=%0d adr=%h dat=%h wait=%0d", v, vecs[v].ch, vecs[v].adr,
               vecs[v].dat, vecs[v].wt);
      start_xfer(vecs[v].ch, vecs[v].adr, vecs[v].dat, 1'b1);
      finish_xfer(vecs[v].ch, vecs[v].adr, vecs[v].dat, vecs[v].wt);
    end

    // Held owner no longer requesting: GRANT falls back to ARB with no bus cycle.
    wait_arb();
    sel = 8'h20; seln = 3'd5; req = 8'h00; ce = 1'b1;
    step();
    ce = 1'b0;
    chk("held_grant_ack", {31'h0, arb_ack_o}, 32'h0);
    step();
    chk("held_cyc", {31'h0, bus_if.cyc_o}, 32'h0);
    chk("held_arb", {31'h0, arb_ack_o}, 32'h1);

    // Zero-wait slave, ack held high from before the grant, back-to-back ch0 then ch7.
    bus_if.ack_i = 1'b1;
    bus_if.dat_i = 16'h0A0A;
    start_xfer(0, 24'h000100, 16'h0A0A, 1'b1);
    step();
    chk("zw0_done_ack", {31'h0, arb_ack_o}, 32'h0);
    step();
    req = 8'h0;
    bus_if.dat_i = 16'h7777;
    start_xfer(7, 24'h070700, 16'h7777, 1'b1);
    step();
    chk("zw7_done_ack", {31'h0, arb_ack_o}, 32'h0);
    step();
    req = 8'h0;
    bus_if.ack_i = 1'b0;

    // Async reset while a cycle is outstanding.
    start_xfer(3, 24'hABCDEF, 16'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbus_cyc", {31'h0, bus_if.cyc_o}, 32'h0);
    chk("rstbus_stb", {31'h0, bus_if.stb_o}, 32'h0);
    chk("rstbus_arb", {31'h0, arb_ack_o}, 32'h1);
    chk("rstbus_adr", {8'h0, bus_if.adr_o}, 32'h0);
    chk("rstbus_dat", {16'h0, dat_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h0;
    step();
    chk("rstbus_after_arb", {31'h0, arb_ack_o}, 32'h1);
    chk("rstbus_after_cyc", {31'h0, bus_if.cyc_o}, 32'h0);

`ifdef PSG_FETCH_TIMEOUT_EN
    begin
      int n = 0;
      start_xfer(1, 24'h00BEEF, 16'h0, 1'b0);
      while (!err_o && n < 20) begin
        step();
        n++;
      end
      chk("to_err", {31'h0, err_o}, 32'h1);
      chk("to_clks", n, 4);
      chk("to_cyc", {31'h0, bus_if.cyc_o}, 32'h0);
      chk("to_rdy", {24'h0, rdy_o}, 32'h0);
      chk("to_arb", {31'h0, arb_ack_o}, 32'h1);
      chk("to_dat", {16'h0, dat_o}, 32'h0);
      req = 8'h0;
      step();
      chk("to_err_pulse", {31'h0, err_o}, 32'h0);
    end
`endif

    repeat (3) step();
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
